// File: rtl/acc_bias_act_pkg.sv
// Shared types and constants for the accumulate/bias/activation stage.
// Build option: ACC_BIAS_ACT_ROUND_EN enables round-half-up before shifting.
package acc_bias_act_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        STALL = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int LEAKY_SHIFT = 3;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_OUT_W   = 16;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_SHIFT_W = 5;

endpackage

// File: rtl/acc_bias_act_if.sv
// Data-in and result-out handshake bundle of acc_bias_act.
interface acc_bias_act_if
    import acc_bias_act_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OUT_W  = DEF_OUT_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/acc_post_proc.sv
// Combinational shift (optional round), leaky-ReLU and signed saturation.
// Build option: ACC_BIAS_ACT_ROUND_EN adds half an LSB before the shift.
module acc_post_proc
    import acc_bias_act_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  logic [DATA_W-1:0]  x_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               leaky_i,
    output logic [OUT_W-1:0]   y_o
);
    localparam logic signed [DATA_W-1:0] MAXV =
        DATA_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [DATA_W-1:0] MINV = ~MAXV;
`ifdef ACC_BIAS_ACT_ROUND_EN
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);
`endif

    logic signed [DATA_W-1:0] r;
    logic signed [DATA_W-1:0] s;
    logic signed [DATA_W-1:0] l;

    always_comb begin
        r = x_i;
`ifdef ACC_BIAS_ACT_ROUND_EN
        if (shift_i != '0) begin
            r = x_i + (ONE << (shift_i - SHIFT_W'(1)));
        end
`endif
        s = r >>> shift_i;
        l = (leaky_i && s[DATA_W-1]) ? (s >>> LEAKY_SHIFT) : s;
        if (l > MAXV) begin
            y_o = MAXV[OUT_W-1:0];
        end else if (l < MINV) begin
            y_o = MINV[OUT_W-1:0];
        end else begin
            y_o = l[OUT_W-1:0];
        end
    end
endmodule

// File: rtl/acc_bias_act.sv
// Windowed bias-seeded accumulator with post-processing and a one-deep
// output register; repeats cfg_n_out windows per start.
module acc_bias_act
    import acc_bias_act_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_n_out,
    input  logic [DATA_W-1:0]  cfg_bias,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               cfg_leaky,
    acc_bias_act_if.slave      bus,
    output logic               busy,
    output logic               done,
    output logic               err
);
    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    win_q, win_d;
    logic [CNT_W-1:0]    ocnt_q, ocnt_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    nout_q, nout_d;
    logic [DATA_W-1:0]   bias_q, bias_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic                leaky_q, leaky_d;
    logic [OUT_W-1:0]    odata_q, odata_d;
    logic                ovalid_q, ovalid_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   sum;
    logic [DATA_W-1:0]   pp_in;
    logic [OUT_W-1:0]    pp_out;
    logic                win_last;
    logic                run_last;
    logic                slot_free;

    // STALL holds the closed window's final sum in acc
    assign sum       = acc_q + bus.in_data;
    assign pp_in     = (state_q == STALL) ? acc_q : sum;
    assign win_last  = (win_q == len_q - CNT_W'(1));
    assign run_last  = (ocnt_q == nout_q - CNT_W'(1));
    assign slot_free = !ovalid_q || bus.out_ready;

    acc_post_proc #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W),
        .SHIFT_W(SHIFT_W)
    ) u_post (
        .x_i    (pp_in),
        .shift_i(shift_q),
        .leaky_i(leaky_q),
        .y_o    (pp_out)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        win_d    = win_q;
        ocnt_d   = ocnt_q;
        len_d    = len_q;
        nout_d   = nout_q;
        bias_d   = bias_q;
        shift_d  = shift_q;
        leaky_d  = leaky_q;
        odata_d  = odata_q;
        ovalid_d = ovalid_q && !bus.out_ready;
        done_d   = 1'b0;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_len != '0 && cfg_n_out != '0) begin
                        len_d   = cfg_len;
                        nout_d  = cfg_n_out;
                        bias_d  = cfg_bias;
                        shift_d = cfg_shift;
                        leaky_d = cfg_leaky;
                        acc_d   = cfg_bias;
                        win_d   = '0;
                        ocnt_d  = '0;
                        err_d   = 1'b0;
                        state_d = ACC;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ACC: begin
                if (bus.in_valid) begin
                    if (win_last) begin
                        win_d = '0;
                        if (slot_free) begin
                            odata_d  = pp_out;
                            ovalid_d = 1'b1;
                            acc_d    = bias_q;
                            ocnt_d   = ocnt_q + CNT_W'(1);
                            state_d  = run_last ? DRAIN : ACC;
                        end else begin
                            acc_d   = sum;
                            state_d = STALL;
                        end
                    end else begin
                        acc_d = sum;
                        win_d = win_q + CNT_W'(1);
                    end
                end
            end
            STALL: begin
                if (bus.in_valid) begin
                    err_d = 1'b1;
                end
                if (bus.out_ready) begin
                    odata_d  = pp_out;
                    ovalid_d = 1'b1;
                    acc_d    = bias_q;
                    ocnt_d   = ocnt_q + CNT_W'(1);
                    state_d  = run_last ? DRAIN : ACC;
                end
            end
            DRAIN: begin
                if (ovalid_q && bus.out_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            win_q    <= '0;
            ocnt_q   <= '0;
            len_q    <= '0;
            nout_q   <= '0;
            bias_q   <= '0;
            shift_q  <= '0;
            leaky_q  <= 1'b0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            win_q    <= win_d;
            ocnt_q   <= ocnt_d;
            len_q    <= len_d;
            nout_q   <= nout_d;
            bias_q   <= bias_d;
            shift_q  <= shift_d;
            leaky_q  <= leaky_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.out_valid = ovalid_q;
    assign bus.out_data  = odata_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_acc_bias_act.sv
// Directed self-checking bench for acc_bias_act.
module tb_acc_bias_act;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_len;
    logic [15:0] cfg_n_out;
    logic [31:0] cfg_bias;
    logic [4:0]  cfg_shift;
    logic        cfg_leaky;
    logic        busy, done, err;

    int n_chk  = 0;
    int n_fail = 0;

    acc_bias_act_if #(.DATA_W(32), .OUT_W(16)) bus ();

    acc_bias_act dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_len  (cfg_len),
        .cfg_n_out(cfg_n_out),
        .cfg_bias (cfg_bias),
        .cfg_shift(cfg_shift),
        .cfg_leaky(cfg_leaky),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] len, input logic [15:0] n,
                            input logic [31:0] bias, input logic [4:0] sh,
                            input logic lk);
        cfg_len   = len;
        cfg_n_out = n;
        cfg_bias  = bias;
        cfg_shift = sh;
        cfg_leaky = lk;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic feed(input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_chk++;
        if ({bus.out_valid, busy, done, err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.out_valid, busy, done, err});
        end
        n_chk++;
        if (bus.out_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0000", bus.out_data);
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        do_start(16'd4, 16'd1, 32'd10, 5'd0, 1'b0);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        bus.in_valid = 1'b1;
        bus.in_data = 32'd1; tick();
        bus.in_data = 32'd2; tick();
        bus.in_data = 32'd3; tick();
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early: got %b want 0", bus.out_valid);
        end
        bus.in_data = 32'd4; tick();
        bus.in_valid = 1'b0;
        n_chk++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 16'd20}) begin
            n_fail++;
            $display("FAIL basic_out: got %b/%h want 1/0014",
                     bus.out_valid, bus.out_data);
        end
        tick();
        n_chk++;
        if ({done, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_done: got %b want 10",
                     {done, bus.out_valid});
        end
        tick();
        n_chk++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_idle: got %b want 00", {done, busy});
        end
    endtask

    task automatic test_shift();
        logic [15:0] last;
`ifdef ACC_BIAS_ACT_ROUND_EN
        last = 16'h0001;
`else
        last = 16'h0000;
`endif
        bus.out_ready = 1'b1;
        do_start(16'd2, 16'd3, 32'd0, 5'd2, 1'b0);
        feed(32'd8);
        feed(32'd8);
        n_chk++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 16'h0004}) begin
            n_fail++;
            $display("FAIL shift_o1: got %b/%h want 1/0004",
                     bus.out_valid, bus.out_data);
        end
        feed(-32'sd8);
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL shift_fall: got %b want 0", bus.out_valid);
        end
        feed(-32'sd4);
        n_chk++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 16'hFFFD}) begin
            n_fail++;
            $display("FAIL shift_o2: got %b/%h want 1/fffd",
                     bus.out_valid, bus.out_data);
        end
        feed(32'd3);
        feed(32'd0);
        n_chk++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, last}) begin
            n_fail++;
            $display("FAIL shift_o3: got %b/%h want 1/%h",
                     bus.out_valid, bus.out_data, last);
        end
        tick();
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL shift_done: got %b want 1", done);
        end
        tick();
    endtask

    task automatic test_leaky_sat();
        bus.out_ready = 1'b1;
        do_start(16'd1, 16'd2, 32'd0, 5'd0, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data = -32'sd64; tick();
        n_chk++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 16'hFFF8}) begin
            n_fail++;
            $display("FAIL leaky_neg: got %b/%h want 1/fff8",
                     bus.out_valid, bus.out_data);
        end
        bus.in_data = 32'd100000; tick();
        bus.in_valid = 1'b0;
        n_chk++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 16'h7FFF}) begin
            n_fail++;
            $display("FAIL leaky_sat: got %b/%h want 1/7fff",
                     bus.out_valid, bus.out_data);
        end
        tick();
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL leaky_done: got %b want 1", done);
        end
        tick();
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        do_start(16'd1, 16'd3, 32'd0, 5'd0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data = 32'd5; tick();
        bus.in_data = 32'd6; tick();
        n_chk++;
        if ({bus.out_valid, bus.out_data, err} !== {1'b1, 16'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_hold: got %b/%h/%b want 1/0005/0",
                     bus.out_valid, bus.out_data, err);
        end
        bus.in_data = 32'd7; tick();
        bus.in_valid = 1'b0;
        n_chk++;
        if ({bus.out_data, err} !== {16'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_err: got %h/%b want 0005/1",
                     bus.out_data, err);
        end
        bus.out_ready = 1'b1;
        tick();
        n_chk++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 16'd6}) begin
            n_fail++;
            $display("FAIL stall_o2: got %b/%h want 1/0006",
                     bus.out_valid, bus.out_data);
        end
        tick();
        n_chk++;
        if ({bus.out_valid, busy, done} !== 3'b010) begin
            n_fail++;
            $display("FAIL stall_wait: got %b want 010",
                     {bus.out_valid, busy, done});
        end
        feed(32'd9);
        n_chk++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 16'd9}) begin
            n_fail++;
            $display("FAIL stall_o3: got %b/%h want 1/0009",
                     bus.out_valid, bus.out_data);
        end
        tick();
        n_chk++;
        if ({done, err} !== 2'b11) begin
            n_fail++;
            $display("FAIL stall_done: got %b want 11", {done, err});
        end
        tick();
    endtask

    task automatic test_zero_len();
        bus.out_ready = 1'b1;
        do_start(16'd0, 16'd3, 32'd0, 5'd0, 1'b0);
        n_chk++;
        if ({done, busy, bus.out_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_done: got %b want 100",
                     {done, busy, bus.out_valid});
        end
        tick();
        n_chk++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL zero_after: got %b want 00", {done, busy});
        end
    endtask

    task automatic test_start_busy();
        bus.out_ready = 1'b1;
        do_start(16'd1, 16'd1, 32'd0, 5'd0, 1'b0);
        n_chk++;
        if ({busy, err} !== 2'b10) begin
            n_fail++;
            $display("FAIL busy_errclr: got %b want 10", {busy, err});
        end
        do_start(16'd2, 16'd1, 32'd100, 5'd1, 1'b0);
        feed(32'd3);
        n_chk++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 16'd3}) begin
            n_fail++;
            $display("FAIL busy_ignore: got %b/%h want 1/0003",
                     bus.out_valid, bus.out_data);
        end
        tick();
        tick();
    endtask

    task automatic test_abort();
        bus.out_ready = 1'b1;
        do_start(16'd4, 16'd1, 32'd0, 5'd0, 1'b0);
        feed(32'd1);
        feed(32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if ({bus.out_valid, busy, done, err, bus.out_data} !==
            {4'b0000, 16'd0}) begin
            n_fail++;
            $display("FAIL abort_rst: got %b/%h want 0000/0000",
                     {bus.out_valid, busy, done, err}, bus.out_data);
        end
        do_start(16'd2, 16'd1, 32'd5, 5'd0, 1'b0);
        feed(32'd10);
        feed(32'd20);
        n_chk++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 16'd35}) begin
            n_fail++;
            $display("FAIL abort_fresh: got %b/%h want 1/0023",
                     bus.out_valid, bus.out_data);
        end
        tick();
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_done: got %b want 1", done);
        end
        tick();
    endtask

    initial begin
        rst           = 1'b0;
        start         = 1'b0;
        cfg_len       = '0;
        cfg_n_out     = '0;
        cfg_bias      = '0;
        cfg_shift     = '0;
        cfg_leaky     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_shift();
        test_leaky_sat();
        test_stall();
        test_zero_len();
        test_start_busy();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
